// File: rtl/fb_write_queue.sv
// fb_write_queue: buffers painter commands ahead of frame-buffer port A and
// provides a full-screen clear sweep. Command word: {en, 3'bx, rgb444, addr16}.
// Optional build macro FBQ_COALESCE_EN: drops an enabled command identical to
// the most recently enqueued entry and counts it on coalesce_cnt.
module fb_write_queue #(
   parameter int          DEPTH       = 16,
   parameter int          FB_WORDS    = 65536,
   parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   input  logic [31:0]                cmd_word,
   output logic                       cmd_ready,
   input  logic                       clear_req,
   output logic                       fb_we,
   output logic [15:0]                fb_addr,
   output logic [11:0]                fb_din,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                stall_cnt
`ifdef FBQ_COALESCE_EN
   ,
   output logic [15:0]                coalesce_cnt
`endif
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [15:0] LAST_ADDR = 16'(FB_WORDS - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t state, state_next;

   // Entry layout is {rgb[27:16], addr[15:0]}, the low 28 bits of the command.
   logic [27:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [27:0] head;
   logic        empty, full;
   logic        accept, push, pop;
   logic        dup;
   logic        enter_clear, sweep_done;
   logic [15:0] cnt;
   logic        unused_bits;

   // Bits [30:28] of the command word carry nothing for this block.
   assign unused_bits = ^cmd_word[30:28];

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level     = wr_ptr - rd_ptr;
   assign head      = mem[rd_ptr[AW-1:0]];

   assign cmd_ready = ~rst & (state == RUN) & ~full;
   assign accept    = cmd_valid & cmd_ready;
   assign push      = accept & cmd_word[31] & ~dup;
   assign pop       = ((state == RUN) || (state == FLUSH)) & ~empty;

   assign enter_clear = (state == FLUSH) & empty;
   assign sweep_done  = (state == CLEAR) & (cnt == LAST_ADDR);

   assign busy = (state != RUN) | (level != '0) | fb_we;

`ifdef FBQ_COALESCE_EN
   logic        last_valid;
   logic [27:0] last_entry;

   assign dup = last_valid & (last_entry == cmd_word[27:0]);

   // Remember the most recent enqueued entry; forget it when a sweep begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_valid <= 1'b0;
         last_entry <= '0;
      end else if (enter_clear) begin
         last_valid <= 1'b0;
      end else if (push) begin
         last_valid <= 1'b1;
         last_entry <= cmd_word[27:0];
      end
   end

   // Count enabled commands that were swallowed as duplicates, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coalesce_cnt <= '0;
      end else if (accept && cmd_word[31] && dup && coalesce_cnt != 16'hFFFF) begin
         coalesce_cnt <= coalesce_cnt + 16'd1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: a clear request first drains the queue, then sweeps.
   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (clear_req) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (enter_clear) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            if (sweep_done) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // Queue storage; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= cmd_word[27:0];
      end
   end

   // Read and write pointers carry one extra bit to tell full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Registered write port: queue head when draining, sweep address when clearing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_din  <= '0;
         cnt     <= '0;
      end else if (pop) begin
         fb_we   <= 1'b1;
         fb_addr <= head[15:0];
         fb_din  <= head[27:16];
      end else if (state == CLEAR) begin
         fb_we   <= 1'b1;
         fb_addr <= cnt;
         fb_din  <= CLEAR_COLOR;
         cnt     <= sweep_done ? 16'd0 : cnt + 16'd1;
      end else begin
         fb_we   <= 1'b0;
      end
   end

   // Count cycles where the producer was held off, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (cmd_valid && !cmd_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fb_write_queue.sv
// Testbench for fb_write_queue: directed scenarios plus random traffic checked
// cycle by cycle against a queue-based behavioural model.
module tb_fb_write_queue;

   localparam int          DEPTH       = 16;
   localparam int          FB_WORDS    = 8;
   localparam logic [11:0] CLEAR_COLOR = 12'h00F;
`ifdef FBQ_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [31:0] cmd_word;
   logic        cmd_ready;
   logic        clear_req;
   logic        fb_we;
   logic [15:0] fb_addr;
   logic [11:0] fb_din;
   logic        busy;
   logic [4:0]  level;
   logic [15:0] stall_cnt;
`ifdef FBQ_COALESCE_EN
   logic [15:0] coalesce_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Behavioural model: mode 0 = accepting, 1 = draining before clear, 2 = sweeping.
   logic [27:0] mq[$];
   int          mode;
   int          sweep;
   logic        mWe;
   logic [15:0] mAddr;
   logic [11:0] mDin;
   int          mStall;
   int          mCoal;
   bit          lastValid;
   logic [27:0] lastEntry;

   fb_write_queue #(
      .DEPTH(DEPTH), .FB_WORDS(FB_WORDS), .CLEAR_COLOR(CLEAR_COLOR)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
      .cmd_ready(cmd_ready), .clear_req(clear_req), .fb_we(fb_we),
      .fb_addr(fb_addr), .fb_din(fb_din), .busy(busy), .level(level),
      .stall_cnt(stall_cnt)
`ifdef FBQ_COALESCE_EN
      , .coalesce_cnt(coalesce_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
      end
   endtask

   function automatic bit mdlReady();
      return (mode == 0) && (mq.size() < DEPTH);
   endfunction

   task automatic modelReset();
      mq.delete();
      mode = 0; sweep = 0;
      mWe = 1'b0; mAddr = '0; mDin = '0;
      mStall = 0; mCoal = 0;
      lastValid = 1'b0; lastEntry = '0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelEdge();
      bit          rdy = mdlReady();
      bit          acc = cmd_valid && rdy;
      int          preSize = mq.size();
      int          preMode = mode;
      logic [27:0] h;
      if (preMode != 2 && preSize > 0) begin
         h = mq.pop_front();
         mWe = 1'b1; mAddr = h[15:0]; mDin = h[27:16];
      end else if (preMode == 2) begin
         mWe = 1'b1; mAddr = 16'(sweep); mDin = CLEAR_COLOR;
         sweep++;
         if (sweep == FB_WORDS) begin
            sweep = 0;
            mode = 0;
         end
      end else begin
         mWe = 1'b0;
      end
      if (preMode == 0 && clear_req) begin
         mode = 1;
      end else if (preMode == 1 && preSize == 0) begin
         mode = 2;
         lastValid = 1'b0;
      end
      if (acc && cmd_word[31]) begin
         if (COAL && lastValid && lastEntry == cmd_word[27:0]) begin
            if (mCoal < 65535) mCoal++;
         end else begin
            mq.push_back(cmd_word[27:0]);
            lastValid = 1'b1;
            lastEntry = cmd_word[27:0];
         end
      end
      if (cmd_valid && !rdy && mStall < 65535) mStall++;
   endtask

   task automatic checkAfterEdge();
      checkOutput("fb_we", fb_we, mWe);
      checkOutput("fb_addr", fb_addr, mAddr);
      checkOutput("fb_din", fb_din, mDin);
      checkOutput("level", level, mq.size());
      checkOutput("busy", busy, (mode != 0) || (mq.size() != 0) || mWe);
      checkOutput("stall_cnt", stall_cnt, mStall);
`ifdef FBQ_COALESCE_EN
      checkOutput("coalesce_cnt", coalesce_cnt, mCoal);
`endif
   endtask

   // Drive one cycle of inputs, check ready before the edge and state after it.
   task automatic applyStimulus(input bit valid, input logic [31:0] word,
                                input bit clr, output bit acc);
      cmd_valid = valid;
      cmd_word  = word;
      clear_req = clr;
      #1;
      checkOutput("cmd_ready", cmd_ready, mdlReady());
      acc = valid && mdlReady();
      @(posedge clk);
      modelEdge();
      #1;
      checkAfterEdge();
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, acc);
   endtask

   // Assert reset away from any edge and confirm its effect takes hold at once.
   task automatic doReset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      clear_req = 1'b0;
      cmd_word = 32'h0;
      #1;
      checkOutput("rst_fb_we", fb_we, 1'b0);
      checkOutput("rst_level", level, 5'd0);
      checkOutput("rst_ready", cmd_ready, 1'b0);
      checkOutput("rst_fb_addr", fb_addr, 16'h0);
      checkOutput("rst_stall", stall_cnt, 16'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit acc;
      bit reached;
      logic [31:0] w;

      rst = 1'b1;
      doReset();

      // Single command: write visible the cycle after the pop edge.
      applyStimulus(1'b1, 32'h8ABC_0123, 1'b0, acc);
      checkOutput("single_level_after_push", level, 5'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, acc);
      checkOutput("single_we", fb_we, 1'b1);
      checkOutput("single_addr", fb_addr, 16'h0123);
      checkOutput("single_din", fb_din, 12'hABC);
      idle(2);

      // Disabled command is consumed without a write.
      applyStimulus(1'b1, 32'h0FFF_0010, 1'b0, acc);
      checkOutput("disabled_accepted", acc, 1'b1);
      idle(2);

      // Back-to-back burst longer than the queue.
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h8100_0000 | i, 1'b0, acc);
      idle(3);

      // Three commands then a clear sweep.
      applyStimulus(1'b1, 32'h8111_0200, 1'b0, acc);
      applyStimulus(1'b1, 32'h8222_0201, 1'b0, acc);
      applyStimulus(1'b1, 32'h8333_0202, 1'b0, acc);
      applyStimulus(1'b0, 32'h0, 1'b1, acc);
      idle(14);

      // Burst presented while a clear blocks acceptance.
      applyStimulus(1'b0, 32'h0, 1'b1, acc);
      for (int i = 0; i < 20; i++) begin
         acc = 1'b0;
         for (int t = 0; t < 40 && !acc; t++)
            applyStimulus(1'b1, 32'h8400_0300 | i, 1'b0, acc);
         if (!acc) checkOutput("blocked_accept_timeout", 0, 1);
      end
      idle(4);

      // Reset in the middle of a sweep.
      applyStimulus(1'b0, 32'h0, 1'b1, acc);
      reached = 1'b0;
      for (int t = 0; t < 40 && !reached; t++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, acc);
         reached = (mode == 2) && mWe && (mAddr == 16'd3);
      end
      checkOutput("reached_clear_addr3", reached, 1'b1);
      doReset();
      applyStimulus(1'b1, 32'h8555_0077, 1'b0, acc);
      checkOutput("post_reset_accept", acc, 1'b1);
      idle(12);

      // Random traffic over a small value set so repeats occur.
      for (int i = 0; i < 400; i++) begin
         w = {1'b0, 3'($urandom), 4'($urandom_range(0, 2)), 8'h5A,
              12'h0, 4'($urandom_range(0, 3))};
         w[31] = ($urandom % 5) != 0;
         applyStimulus(($urandom % 4) != 0, w, ($urandom % 50) == 0, acc);
      end
      idle(30);

`ifdef FBQ_COALESCE_EN
      // Identical command sent three times yields one write.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h8123_0040, 1'b0, acc);
      idle(3);
      checkOutput("coalesce_total", coalesce_cnt, 16'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
